uart_rx_fifo: RTL and testbench

- Receive-side byte buffer sitting directly downstream of the UART Receiver.
- Captures each byte the Receiver presents on rx_out when rx_done rises, and stores it in a circular FIFO.
- Presents the bytes to the host/consumer through a registered read handshake.
- Reports fill level and a sticky overrun flag, so bytes arriving while the host is busy are not silently lost.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_fifo_ram.sv | 30 +++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receive- and transmit-side buffers.
package uart_pkg;

   localparam int unsigned UART_DATA_WIDTH    = 8;
   localparam int unsigned UART_RX_FIFO_DEPTH = 16;

   // Ceiling log2, used to derive pointer widths from a FIFO depth.
   function automatic int unsigned uart_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-capture and host-read signals between the UART Receiver, the RX FIFO and the consumer.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH
);
   localparam int unsigned ADDR_WIDTH = uart_clog2(DEPTH);

   logic [DATA_WIDTH-1:0] rx_out;
   logic                  rx_done;
   logic                  rd_en;
   logic                  clear_overrun;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  full;
   logic [ADDR_WIDTH:0]   count;
   logic                  overrun;

   modport master (
      output rx_out, rx_done, rd_en, clear_overrun,
      input  rd_data, rd_valid, empty, full, count, overrun
   );

   modport slave (
      input  rx_out, rx_done, rd_en, clear_overrun,
      output rd_data, rd_valid, empty, full, count, overrun
   );
endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_WIDTH storage with one synchronous write and one synchronous read port, no reset.
module uart_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read-before-write: a same-address write lands after the old word is captured.
   always_ff @(posedge clock) begin
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures one byte per rx_done rising edge and serves a registered read port.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH
) (
   input  logic           clock,
   input  logic           reset,
   uart_rx_fifo_if.slave  bus
);

   localparam int unsigned ADDR_WIDTH = uart_clog2(DEPTH);
   localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

   logic                  rx_done_q, rx_done_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overrun_q, overrun_d;
   logic                  rd_seen_q, rd_seen_d;

   logic                  wr_evt;
   logic                  rd_evt;
   logic                  wr_acc;
   logic                  drop;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   always_comb begin
      rx_done_d  = bus.rx_done;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overrun_d  = overrun_q;
      rd_seen_d  = rd_seen_q;

      wr_evt = bus.rx_done & ~rx_done_q;
      rd_evt = bus.rd_en & ~empty_q;
      // A full FIFO still accepts a write when a read frees a slot on the same edge.
      wr_acc = wr_evt & (~full_q | rd_evt);
      drop   = wr_evt & full_q & ~rd_evt;

      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_evt) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

      case ({wr_acc, rd_evt})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase

      if (drop)                   overrun_d = 1'b1;
      else if (bus.clear_overrun) overrun_d = 1'b0;

      if (rd_evt) rd_seen_d = 1'b1;

      empty_d    = (count_d == '0);
      full_d     = (count_d == CNT_WIDTH'(DEPTH));
      rd_valid_d = rd_evt;
   end

   // rx_done_q resets high so a strobe held across reset release is not captured.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_done_q  <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         rx_done_q  <= rx_done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
         rd_seen_q  <= rd_seen_d;
      end
   end

   uart_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clock   (clock),
      .wr_en   (wr_acc & ~reset),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.rx_out),
      .rd_en   (rd_evt & ~reset),
      .rd_addr (rd_ptr_q),
      .rd_data (ram_rd_data)
   );

   // The RAM read register has no reset; report zero until the first read after reset.
   assign bus.rd_data  = rd_seen_q ? ram_rd_data : '0;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for basic capture/read plus hand sequences for corners.
module tb_uart_rx_fifo;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

   uart_rx_fifo dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rx_done;
      logic [7:0] rx_out;
      logic       rd_en;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic [4:0] exp_count;
      logic       exp_empty;
   } vec_t;

   vec_t vecs [18];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input logic [7:0] b);
      bus.rx_done = 1'b1;
      bus.rx_out  = b;
      step();
      bus.rx_done = 1'b0;
      step();
   endtask

   task automatic pop_expect(input string name, input logic [7:0] b);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check({name, " valid"}, 32'(bus.rd_valid), 32'd1);
      check({name, " data"}, 32'(bus.rd_data), 32'(b));
   endtask

   task automatic set_vec(input int i, input logic rd, input logic [7:0] d, input logic re,
                          input logic ev, input logic [7:0] ed, input logic [4:0] ec, input logic ee);
      vecs[i].rx_done   = rd;
      vecs[i].rx_out    = d;
      vecs[i].rd_en     = re;
      vecs[i].exp_valid = ev;
      vecs[i].exp_data  = ed;
      vecs[i].exp_count = ec;
      vecs[i].exp_empty = ee;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      reset             = 1'b1;
      bus.rx_done       = 1'b0;
      bus.rx_out        = '0;
      bus.rd_en         = 1'b0;
      bus.clear_overrun = 1'b0;
      step();
      step();

      check("reset count", 32'(bus.count), 32'd0);
      check("reset empty", 32'(bus.empty), 32'd1);
      check("reset full", 32'(bus.full), 32'd0);
      check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
      check("reset rd_data", 32'(bus.rd_data), 32'd0);
      check("reset overrun", 32'(bus.overrun), 32'd0);
      reset = 1'b0;

      // Three 3-cycle strobes, then three reads and one read while empty.
      set_vec( 0, 0, 8'h00, 0, 0, 8'h00, 5'd0, 1);
      set_vec( 1, 1, 8'h55, 0, 0, 8'h00, 5'd1, 0);
      set_vec( 2, 1, 8'h55, 0, 0, 8'h00, 5'd1, 0);
      set_vec( 3, 1, 8'h55, 0, 0, 8'h00, 5'd1, 0);
      set_vec( 4, 0, 8'h00, 0, 0, 8'h00, 5'd1, 0);
      set_vec( 5, 1, 8'hA3, 0, 0, 8'h00, 5'd2, 0);
      set_vec( 6, 1, 8'hA3, 0, 0, 8'h00, 5'd2, 0);
      set_vec( 7, 1, 8'hA3, 0, 0, 8'h00, 5'd2, 0);
      set_vec( 8, 0, 8'h00, 0, 0, 8'h00, 5'd2, 0);
      set_vec( 9, 1, 8'h0F, 0, 0, 8'h00, 5'd3, 0);
      set_vec(10, 1, 8'h0F, 0, 0, 8'h00, 5'd3, 0);
      set_vec(11, 1, 8'h0F, 0, 0, 8'h00, 5'd3, 0);
      set_vec(12, 0, 8'h00, 0, 0, 8'h00, 5'd3, 0);
      set_vec(13, 0, 8'h00, 1, 1, 8'h55, 5'd2, 0);
      set_vec(14, 0, 8'h00, 1, 1, 8'hA3, 5'd1, 0);
      set_vec(15, 0, 8'h00, 1, 1, 8'h0F, 5'd0, 1);
      set_vec(16, 0, 8'h00, 1, 0, 8'h0F, 5'd0, 1);
      set_vec(17, 0, 8'h00, 0, 0, 8'h0F, 5'd0, 1);

      for (int i = 0; i < 18; i++) begin
         bus.rx_done = vecs[i].rx_done;
         bus.rx_out  = vecs[i].rx_out;
         bus.rd_en   = vecs[i].rd_en;
         step();
         check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
      end
      bus.rd_en = 1'b0;

      // Fill to full, then a dropped 17th byte.
      for (int i = 0; i < 16; i++) push(8'(i));
      check("fill full", 32'(bus.full), 32'd1);
      check("fill count", 32'(bus.count), 32'd16);
      check("fill overrun", 32'(bus.overrun), 32'd0);
      push(8'hFF);
      check("drop overrun", 32'(bus.overrun), 32'd1);
      check("drop count", 32'(bus.count), 32'd16);
      for (int i = 0; i < 16; i++) pop_expect($sformatf("drain%0d", i), 8'(i));
      check("drain empty", 32'(bus.empty), 32'd1);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check("drain no extra", 32'(bus.rd_valid), 32'd0);

      // Write and read on the same edge while full.
      bus.clear_overrun = 1'b1;
      step();
      bus.clear_overrun = 1'b0;
      check("clear overrun", 32'(bus.overrun), 32'd0);
      for (int i = 0; i < 16; i++) push(8'(i));
      bus.rd_en   = 1'b1;
      bus.rx_done = 1'b1;
      bus.rx_out  = 8'h77;
      step();
      bus.rd_en   = 1'b0;
      bus.rx_done = 1'b0;
      check("full rw valid", 32'(bus.rd_valid), 32'd1);
      check("full rw data", 32'(bus.rd_data), 32'h00);
      check("full rw count", 32'(bus.count), 32'd16);
      check("full rw overrun", 32'(bus.overrun), 32'd0);
      step();
      for (int i = 1; i < 16; i++) pop_expect($sformatf("frw%0d", i), 8'(i));
      pop_expect("frw last", 8'h77);
      check("frw empty", 32'(bus.empty), 32'd1);

      // Write and read on the same edge while empty: no fall-through.
      bus.rd_en   = 1'b1;
      bus.rx_done = 1'b1;
      bus.rx_out  = 8'h3C;
      step();
      bus.rx_done = 1'b0;
      check("empty rw valid", 32'(bus.rd_valid), 32'd0);
      check("empty rw count", 32'(bus.count), 32'd1);
      step();
      check("empty rw next valid", 32'(bus.rd_valid), 32'd1);
      check("empty rw next data", 32'(bus.rd_data), 32'h3C);
      check("empty rw next empty", 32'(bus.empty), 32'd1);
      step();
      bus.rd_en = 1'b0;
      check("empty rw after", 32'(bus.rd_valid), 32'd0);

      // rx_done held across reset release, with a byte pending at reset.
      push(8'h11);
      bus.rx_done = 1'b1;
      bus.rx_out  = 8'h99;
      reset       = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst mid rd_data", 32'(bus.rd_data), 32'd0);
      check("rst mid count", 32'(bus.count), 32'd0);
      step();
      check("rst held count", 32'(bus.count), 32'd0);
      step();
      check("rst held count2", 32'(bus.count), 32'd0);
      bus.rx_done = 1'b0;
      step();
      push(8'h5A);
      check("post rst count", 32'(bus.count), 32'd1);
      pop_expect("post rst", 8'h5A);

      // Interleaved traffic across pointer wrap.
      for (int i = 0; i < 24; i++) begin
         push(8'(8'h80 + i));
         pop_expect($sformatf("wrap%0d", i), 8'(8'h80 + i));
      end
      check("wrap empty", 32'(bus.empty), 32'd1);

      // Drop and clear on the same edge: set wins.
      for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
      bus.rx_done       = 1'b1;
      bus.rx_out        = 8'hEE;
      bus.clear_overrun = 1'b1;
      step();
      bus.rx_done       = 1'b0;
      bus.clear_overrun = 1'b0;
      check("set wins overrun", 32'(bus.overrun), 32'd1);
      check("set wins count", 32'(bus.count), 32'd16);
      step();
      check("overrun sticky", 32'(bus.overrun), 32'd1);
      bus.clear_overrun = 1'b1;
      step();
      bus.clear_overrun = 1'b0;
      check("clear alone", 32'(bus.overrun), 32'd0);
      pop_expect("after drop", 8'hC0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
